// File: rtl/usb3_sched_pkg.sv
// Shared definitions for the USB3 IN-endpoint scheduler: state encoding,
// address/length widths and the byte-length to word-count helper.
package usb3_sched_pkg;

  localparam int LEN_W     = 11;
  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 32;
  localparam int MAX_WORDS = 256;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    OFFER       = 3'd1,
    STREAM      = 3'd2,
    WAIT_RESULT = 3'd3,
    ARM         = 3'd4,
    ARM_REL     = 3'd5
  } sched_state_e;

  // Number of 32-bit words needed for a byte length. Lengths above one
  // maximum-size packet are clamped so a corrupt length can never run the
  // read address past the buffer.
  function automatic logic [ADDR_W-1:0] len_to_words(input logic [LEN_W-1:0] len);
    logic [ADDR_W-1:0] words;
    if (len > LEN_W'(1024)) begin
      words = ADDR_W'(MAX_WORDS);
    end else begin
      words = ADDR_W'((len + LEN_W'(3)) >> 2);
    end
    return words;
  endfunction

endpackage

// File: rtl/usb3_rr_arb.sv
// Combinational round-robin arbiter: searches the request vector starting
// at ptr_i and wrapping, returns the first hit as one-hot and index.
// The pointer register is owned by the parent.
module usb3_rr_arb
  import usb3_sched_pkg::*;
#(
  parameter int NUM_EP = 4,
  parameter int EPW    = 2
) (
  input  logic [NUM_EP-1:0] req_i,
  input  logic [EPW-1:0]    ptr_i,
  output logic [NUM_EP-1:0] gnt_o,
  output logic [EPW-1:0]    idx_o,
  output logic              any_o
);

  // First requester at or after the pointer, wrapping at NUM_EP.
  always_comb begin
    logic          found;
    int            s;
    logic [EPW-1:0] j;
    found = 1'b0;
    s     = 0;
    j     = '0;
    gnt_o = '0;
    idx_o = '0;
    for (int k = 0; k < NUM_EP; k++) begin
      s = int'(ptr_i) + k;
      if (s >= NUM_EP) s = s - NUM_EP;
      j = EPW'(s);
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/usb3_ep_sched.sv
// USB3 IN-endpoint scheduler. Picks an endpoint round-robin, offers its
// packet to the protocol layer, streams the buffer words and re-arms the
// endpoint buffer with a 4-phase arm/arm_ack handshake.
//
// Handshakes: the offer (tx_valid/tx_ep/tx_len) is held stable until the
// protocol pulses tx_start for one cycle; tx_start is only honoured while
// tx_valid is high. Streaming has no backpressure: every cycle with
// tx_data_valid high carries one word. tx_result is a one-cycle strobe only
// honoured in WAIT_RESULT, with tx_ack qualifying it. ep_arm rises and stays
// high until ep_arm_ack is seen high, then falls and the block waits for
// ep_arm_ack to fall before scheduling again.
module usb3_ep_sched
  import usb3_sched_pkg::*;
#(
  parameter int NUM_EP      = 4,
  parameter int EPW         = 2,
  parameter int ARM_TIMEOUT = 15
) (
  input  logic                       local_clk,
  input  logic                       reset_n,
  input  logic [NUM_EP-1:0]          ep_enable,
  input  logic [NUM_EP-1:0]          ep_hasdata,
  input  logic [NUM_EP*LEN_W-1:0]    ep_len,
  input  logic [NUM_EP*DATA_W-1:0]   ep_q,
  output logic [ADDR_W-1:0]          ep_addr,
  output logic [NUM_EP-1:0]          ep_arm,
  input  logic [NUM_EP-1:0]          ep_arm_ack,
  output logic                       tx_valid,
  output logic [EPW-1:0]             tx_ep,
  output logic [LEN_W-1:0]           tx_len,
  input  logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_data_valid,
  output logic                       tx_data_last,
  input  logic                       tx_result,
  input  logic                       tx_ack,
  output logic                       err_timeout
);

  localparam int TMR_W = $clog2(ARM_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ARM_TIMEOUT - 1);

  sched_state_e      state_q, state_d;
  logic [EPW-1:0]    cur_ep_q, cur_ep_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [EPW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dv_q, dv_d;
  logic              last_q, last_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              err_q, err_d;

  logic [NUM_EP-1:0] eligible;
  logic [NUM_EP-1:0] arb_gnt;
  logic [EPW-1:0]    arb_idx;
  logic              arb_any;
  logic [LEN_W-1:0]  len_sel;
  logic [ADDR_W-1:0] nwords;
  logic              ack_cur;
  logic              en_cur;

  assign eligible = ep_enable & ep_hasdata;
  assign nwords   = len_to_words(len_q);
  assign ack_cur  = ep_arm_ack[cur_ep_q];
  assign en_cur   = ep_enable[cur_ep_q];

  usb3_rr_arb #(
    .NUM_EP (NUM_EP),
    .EPW    (EPW)
  ) u_arb (
    .req_i (eligible),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // AND-OR select of the winning endpoint's length using the one-hot grant.
  always_comb begin
    len_sel = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (arb_gnt[i]) len_sel = len_sel | ep_len[i*LEN_W +: LEN_W];
    end
  end

  // State and datapath registers; async clear puts every output at 0.
  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cur_ep_q <= '0;
      len_q    <= '0;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      dv_q     <= 1'b0;
      last_q   <= 1'b0;
      timer_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_ep_q <= cur_ep_d;
      len_q    <= len_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      dv_q     <= dv_d;
      last_q   <= last_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic for arbitration, offer, streaming and arm handshake.
  always_comb begin
    state_d  = state_q;
    cur_ep_d = cur_ep_q;
    len_d    = len_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    dv_d     = 1'b0;
    last_d   = 1'b0;
    timer_d  = timer_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          cur_ep_d = arb_idx;
          len_d    = len_sel;
          rr_ptr_d = (arb_idx == EPW'(NUM_EP - 1)) ? '0 : arb_idx + EPW'(1);
          state_d  = OFFER;
        end
      end
      OFFER: begin
        // An accepted offer wins over a same-cycle disable: the protocol
        // has already committed to the packet.
        if (tx_start) begin
          addr_d  = '0;
          state_d = (nwords == '0) ? WAIT_RESULT : STREAM;
        end else if (!en_cur) begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        // The word for addr_q arrives from the RAM one cycle later, so the
        // qualifier is registered alongside the issue.
        dv_d   = 1'b1;
        last_d = (addr_q == nwords - ADDR_W'(1));
        if (addr_q == nwords - ADDR_W'(1)) begin
          addr_d  = '0;
          state_d = WAIT_RESULT;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      WAIT_RESULT: begin
        if (tx_result) begin
          if (tx_ack) begin
            timer_d = '0;
            state_d = ARM;
          end else begin
            state_d = OFFER;
          end
        end
      end
      ARM: begin
        if (ack_cur) begin
          timer_d = '0;
          state_d = ARM_REL;
        end else if (timer_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ARM_REL: begin
        if (!ack_cur) begin
          state_d = IDLE;
        end else if (timer_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arm request for the current endpoint only while in ARM.
  always_comb begin
    ep_arm = '0;
    if (state_q == ARM) ep_arm[cur_ep_q] = 1'b1;
  end

  assign ep_addr       = addr_q;
  assign tx_valid      = (state_q == OFFER);
  assign tx_ep         = tx_valid ? cur_ep_q : '0;
  assign tx_len        = tx_valid ? len_q : '0;
  assign tx_data_valid = dv_q;
  assign tx_data_last  = last_q;
  assign tx_data       = dv_q ? ep_q[cur_ep_q*DATA_W +: DATA_W] : '0;
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_usb3_ep_sched.sv
// Scoreboard bench for usb3_ep_sched: directed packets push expected
// offers, beats, arm requests and timeouts; a negedge monitor pops and
// compares whenever the DUT presents the corresponding output.
module tb_usb3_ep_sched;
  import usb3_sched_pkg::*;

  localparam int NUM_EP      = 4;
  localparam int EPW         = 2;
  localparam int ARM_TIMEOUT = 15;

  logic         local_clk = 1'b0;
  logic         reset_n   = 1'b0;
  logic [3:0]   ep_enable  = '0;
  logic [3:0]   ep_hasdata = '0;
  logic [43:0]  ep_len     = '0;
  logic [127:0] ep_q       = '0;
  logic [8:0]   ep_addr;
  logic [3:0]   ep_arm;
  logic [3:0]   ep_arm_ack = '0;
  logic         tx_valid;
  logic [1:0]   tx_ep;
  logic [10:0]  tx_len;
  logic         tx_start  = 1'b0;
  logic [31:0]  tx_data;
  logic         tx_data_valid;
  logic         tx_data_last;
  logic         tx_result = 1'b0;
  logic         tx_ack    = 1'b0;
  logic         err_timeout;

  int total = 0;
  int bad   = 0;

  logic [12:0] offer_q[$];  // {ep, len}
  logic [32:0] exp_q[$];    // {last, data}
  logic [3:0]  arm_q[$];    // one-hot ep_arm expected at rise
  int          err_q[$];    // cycles from arm rise to err_timeout

  int         beats_seen = 0;
  int         arm_cnt    = 0;
  logic       prev_valid = 1'b0;
  logic [3:0] prev_arm   = '0;

  usb3_ep_sched #(
    .NUM_EP      (NUM_EP),
    .EPW         (EPW),
    .ARM_TIMEOUT (ARM_TIMEOUT)
  ) dut (
    .local_clk     (local_clk),
    .reset_n       (reset_n),
    .ep_enable     (ep_enable),
    .ep_hasdata    (ep_hasdata),
    .ep_len        (ep_len),
    .ep_q          (ep_q),
    .ep_addr       (ep_addr),
    .ep_arm        (ep_arm),
    .ep_arm_ack    (ep_arm_ack),
    .tx_valid      (tx_valid),
    .tx_ep         (tx_ep),
    .tx_len        (tx_len),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_last  (tx_data_last),
    .tx_result     (tx_result),
    .tx_ack        (tx_ack),
    .err_timeout   (err_timeout)
  );

  // ---------------- clock / reset ----------------
  always #5 local_clk = ~local_clk;

  // Endpoint buffer RAM contents: a recognisable word per (ep, addr).
  function automatic logic [31:0] word_of(input int ep, input logic [8:0] a);
    return {8'hE0 + 8'(ep), 8'h5A, 7'h00, a};
  endfunction

  // Each endpoint RAM reads the broadcast address with 1-cycle latency.
  always @(posedge local_clk) begin
    for (int i = 0; i < NUM_EP; i++) ep_q[i*32 +: 32] <= word_of(i, ep_addr);
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_unexpected(input string name, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected nothing (t=%0t)", name, act, $time);
  endtask

  // ---------------- monitor ----------------
  always @(negedge local_clk) begin
    if (tx_valid && !prev_valid) begin
      if (offer_q.size() == 0) fail_unexpected("offer", 64'({tx_ep, tx_len}));
      else check("offer", 64'({tx_ep, tx_len}), 64'(offer_q.pop_front()));
    end
    if (tx_data_valid) begin
      beats_seen++;
      if (exp_q.size() == 0) fail_unexpected("beat", 64'({tx_data_last, tx_data}));
      else check("beat", 64'({tx_data_last, tx_data}), 64'(exp_q.pop_front()));
    end
    if (ep_arm != 4'b0 && prev_arm == 4'b0) begin
      arm_cnt = 0;
      if (arm_q.size() == 0) fail_unexpected("arm_rise", 64'(ep_arm));
      else check("arm_rise", 64'(ep_arm), 64'(arm_q.pop_front()));
    end else begin
      arm_cnt++;
    end
    if (err_timeout) begin
      if (err_q.size() == 0) fail_unexpected("err_timeout", 64'(arm_cnt));
      else begin
        check("err_timeout_delay", 64'(arm_cnt), 64'(err_q.pop_front()));
        check("arm_drop_on_timeout", 64'(ep_arm), 64'(0));
      end
    end
    prev_valid = tx_valid;
    prev_arm   = ep_arm;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge local_clk);
    #1;
  endtask

  task automatic set_len(input int ep, input int len);
    ep_len[ep*11 +: 11] = 11'(len);
  endtask

  // One offer/stream/result cycle; nw is the hand-computed word count.
  task automatic do_packet(input int ep, input int len, input int nw,
                           input logic ack, input logic [3:0] clr);
    int n;
    offer_q.push_back({2'(ep), 11'(len)});
    for (int w = 0; w < nw; w++) exp_q.push_back({(w == nw - 1), word_of(ep, 9'(w))});
    n = 0;
    while (!tx_valid && n < 2000) begin tick(); n++; end
    check("offer_wait", 64'(tx_valid), 64'(1));
    tx_start = 1'b1;
    tick();
    tx_start   = 1'b0;
    ep_hasdata = ep_hasdata & ~clr;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin tick(); n++; end
    check("stream_done", 64'(exp_q.size()), 64'(0));
    check("addr_back_to_0", 64'(ep_addr), 64'(0));
    if (ack) arm_q.push_back(4'b0001 << ep);
    tx_result = 1'b1;
    tx_ack    = ack;
    tick();
    tx_result = 1'b0;
    tx_ack    = 1'b0;
  endtask

  // Endpoint side of the 4-phase arm handshake.
  task automatic arm_seq(input int ep, input int dly);
    int n;
    n = 0;
    while (!ep_arm[ep] && n < 50) begin tick(); n++; end
    check("arm_seen", 64'(ep_arm[ep]), 64'(1));
    for (int d = 0; d < dly; d++) begin
      tick();
      check("arm_hold", 64'(ep_arm), 64'(4'b0001 << ep));
    end
    ep_arm_ack[ep] = 1'b1;
    n = 0;
    while (ep_arm[ep] && n < 50) begin tick(); n++; end
    check("arm_release", 64'(ep_arm), 64'(0));
    ep_arm_ack[ep] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int base;
    ep_enable = 4'b1111;
    #2;
    check("rst_tx_valid", 64'(tx_valid), 64'(0));
    check("rst_tx_data_valid", 64'(tx_data_valid), 64'(0));
    check("rst_ep_arm", 64'(ep_arm), 64'(0));
    check("rst_ep_addr", 64'(ep_addr), 64'(0));
    check("rst_err", 64'(err_timeout), 64'(0));
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("idle_no_offer", 64'(tx_valid), 64'(0));

    // Round robin: all eligible, order 0,1,2,3,0.
    set_len(0, 4); set_len(1, 8); set_len(2, 12); set_len(3, 16);
    ep_hasdata = 4'b1111;
    do_packet(0, 4, 1, 1'b1, 4'b0000);  arm_seq(0, 1);
    do_packet(1, 8, 2, 1'b1, 4'b0000);  arm_seq(1, 0);
    do_packet(2, 12, 3, 1'b1, 4'b0000); arm_seq(2, 2);
    do_packet(3, 16, 4, 1'b1, 4'b0000); arm_seq(3, 1);
    do_packet(0, 4, 1, 1'b1, 4'b1111);  arm_seq(0, 1);

    // Single endpoint, len 10 -> 3 words.
    set_len(1, 10);
    ep_hasdata = 4'b0010;
    do_packet(1, 10, 3, 1'b1, 4'b0010); arm_seq(1, 2);

    // Zero-length packet on ep2.
    set_len(2, 0);
    ep_hasdata = 4'b0100;
    do_packet(2, 0, 0, 1'b1, 4'b0100); arm_seq(2, 1);

    // Retry: len 1024 -> 256 words, NAK then ACK.
    set_len(3, 1024);
    ep_hasdata = 4'b1000;
    do_packet(3, 1024, 256, 1'b0, 4'b0000);
    do_packet(3, 1024, 256, 1'b1, 4'b1000); arm_seq(3, 0);

    // Arm timeout on ep0, then ep1 is offered.
    set_len(0, 8); set_len(1, 12);
    ep_hasdata = 4'b0011;
    err_q.push_back(ARM_TIMEOUT);
    do_packet(0, 8, 2, 1'b1, 4'b0001);
    n = 0;
    while (err_q.size() != 0 && n < 100) begin tick(); n++; end
    check("timeout_seen", 64'(err_q.size()), 64'(0));
    check("arm_low_after_timeout", 64'(ep_arm), 64'(0));
    do_packet(1, 12, 3, 1'b1, 4'b0010); arm_seq(1, 1);

    // Async reset at beat 5 of a 10-word packet on ep2.
    set_len(2, 40);
    ep_hasdata = 4'b0100;
    offer_q.push_back({2'd2, 11'd40});
    for (int w = 0; w < 10; w++) exp_q.push_back({(w == 9), word_of(2, 9'(w))});
    n = 0;
    while (!tx_valid && n < 100) begin tick(); n++; end
    check("rst_test_offer_wait", 64'(tx_valid), 64'(1));
    base = beats_seen;
    tx_start = 1'b1;
    tick();
    tx_start   = 1'b0;
    ep_hasdata = 4'b0000;
    n = 0;
    while (beats_seen < base + 5 && n < 100) begin tick(); n++; end
    check("rst_test_beat5", 64'(beats_seen - base), 64'(5));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_data_valid", 64'(tx_data_valid), 64'(0));
    check("async_rst_tx_valid", 64'(tx_valid), 64'(0));
    check("async_rst_ep_arm", 64'(ep_arm), 64'(0));
    check("async_rst_ep_addr", 64'(ep_addr), 64'(0));
    exp_q.delete();
    set_len(0, 4); set_len(3, 16);
    ep_hasdata = 4'b1001;
    repeat (2) tick();
    reset_n = 1'b1;
    // Pointer restarts at 0: ep0 wins over ep3.
    do_packet(0, 4, 1, 1'b1, 4'b1001); arm_seq(0, 1);

    repeat (5) tick();
    check("offers_drained", 64'(offer_q.size()), 64'(0));
    check("beats_drained", 64'(exp_q.size()), 64'(0));
    check("arms_drained", 64'(arm_q.size()), 64'(0));
    check("final_idle", 64'(tx_valid), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/usb3_ep_sched.md
Name: usb3_ep_sched

Overview:
- Scheduler for NUM_EP double-buffered IN endpoint buffers.
- Round-robin arbitration among endpoints reporting hasdata. Offers the winner to the protocol layer and streams its buffer words out via a shared read address.
- On protocol success, re-arms the endpoint with a 4-phase arm/arm_ack handshake.
- Sits between the endpoint buffer instances and the USB3 protocol-layer transmitter, in the local_clk domain.

Parameters:
- NUM_EP, 4, number of scheduled endpoints (2..8).
- EPW, 2, width of endpoint index; must equal clog2(NUM_EP).
- ARM_TIMEOUT, 15, cycles to wait for each arm_ack edge before aborting.

Ports:
- local_clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- ep_enable  in  NUM_EP  per-endpoint scheduling enable.
- ep_hasdata  in  NUM_EP  per-endpoint buf_out_hasdata.
- ep_len  in  NUM_EP*11  per-endpoint buf_out_len, endpoint i at [11i+10:11i].
- ep_q  in  NUM_EP*32  per-endpoint buf_out_q; RAM read latency is 1 cycle.
- ep_addr  out  9  word address, broadcast to every endpoint's buf_out_addr.
- ep_arm  out  NUM_EP  per-endpoint buf_out_arm.
- ep_arm_ack  in  NUM_EP  per-endpoint buf_out_arm_ack.
- tx_valid  out  1  packet offered.
- tx_ep  out  EPW  offered endpoint index.
- tx_len  out  11  offered byte length.
- tx_start  in  1  protocol accepts offer; starts streaming.
- tx_data  out  32  streamed word.
- tx_data_valid  out  1  tx_data qualifier.
- tx_data_last  out  1  final word of packet.
- tx_result  in  1  single-cycle packet outcome strobe.
- tx_ack  in  1  outcome qualifier with tx_result: 1 = delivered, 0 = retry.
- err_timeout  out  1  single-cycle arm handshake timeout pulse.

Behaviour:
- Reset (async assert, sync deassert inside block):
  - all outputs 0; state IDLE; rr_ptr = 0.
- Eligibility: eligible[i] = ep_enable[i] & ep_hasdata[i].
- Arbitration in IDLE:
  - Search eligible from rr_ptr upward with wrap. The first hit is latched as cur_ep, together with len = ep_len[cur_ep].
  - rr_ptr <= cur_ep+1 mod NUM_EP. Move to OFFER.
  - No eligible endpoint: stay in IDLE.
- OFFER:
  - tx_valid=1, tx_ep=cur_ep, tx_len=latched len. These hold stable until tx_start.
  - nwords = (len+3)>>2; len > 1024 is clamped to 256 words.
  - tx_start with nwords=0 (ZLP): go to WAIT_RESULT, no data beats.
  - tx_start otherwise: tx_valid falls next cycle, ep_addr=0, go to STREAM.
  - Endpoint disabled while in OFFER: drop the offer, return to IDLE.
- STREAM:
  - ep_addr increments each cycle from 0 to nwords-1.
  - tx_data_valid is ep_addr-issue delayed by 1 cycle. tx_data = ep_q[cur_ep] registered mux.
  - tx_data_last accompanies beat nwords-1.
  - No backpressure. After the last beat, go to WAIT_RESULT; ep_addr returns to 0.
- WAIT_RESULT:
  - tx_result & tx_ack: go to ARM.
  - tx_result & ~tx_ack: go to OFFER with same cur_ep/len (retry; buffer not released).
  - tx_result outside WAIT_RESULT is ignored.
- ARM:
  - ep_arm[cur_ep]=1 until ep_arm_ack[cur_ep] is sampled 1, then go to ARM_REL.
- ARM_REL:
  - ep_arm=0; wait for ep_arm_ack[cur_ep]=0, then go to IDLE.
  - This guarantees the rising edge is seen exactly once by the endpoint's synchronizer.
- Arm timeout: counter cleared on entry to ARM and to ARM_REL.
  - Reaching ARM_TIMEOUT in either state pulses err_timeout for 1 cycle, drops ep_arm, and goes to IDLE.
- Back-to-back: minimum 1 IDLE cycle between packets.
  - The same endpoint may win again only if no other endpoint is eligible.
- Reset mid-STREAM/ARM: outputs clear asynchronously; a partially armed endpoint is not acked. Endpoint-side recovery is handled by its own reset.

Decomposition:
- Shared package usb3_sched_pkg:
  - state encoding (IDLE, OFFER, STREAM, WAIT_RESULT, ARM, ARM_REL);
  - MAX_WORDS=256;
  - LEN_W=11, ADDR_W=9.
- One natural sub-module: usb3_rr_arb (NUM_EP request vector + rr_ptr -> one-hot grant, index, any). Purely combinational; the pointer register lives in the parent.

Test Plan:
- Single endpoint: ep1 hasdata, len=10, tx_start → tx_valid tx_ep=1 tx_len=10; 3 beats on ep_addr 0,1,2; last on beat 3. tx_result/tx_ack=1 → ep_arm[1] high until ack, low after ack falls.
- Round robin: all 4 endpoints eligible, each packet acked → grant order 0,1,2,3,0, with ≥1 IDLE cycle between offers.
- Retry: len=1024, tx_result with tx_ack=0 → re-offer same ep and len; no ep_arm. Second stream gives 256 beats with last on beat 256, and addresses wrap back to 0.
- ZLP: len=0, tx_start → no tx_data_valid; tx_result/tx_ack=1 → arm sequence completes normally.
- Timeout: ep_arm_ack held 0 → err_timeout pulse exactly ARM_TIMEOUT cycles after ARM entry; ep_arm drops; state IDLE; next eligible endpoint offered.
- Async reset asserted mid-STREAM (beat 5) → tx_data_valid, tx_valid, ep_arm 0 immediately. After release, scheduling restarts with rr_ptr=0.
